// File: rtl/adder_tree_pkg.sv
// Shared constants and FSM state type for the adder-tree sequencer slice.
package adder_tree_pkg;
  localparam int ACC_W = 66;

  localparam logic [1:0] MODE_HALF    = 2'b00;
  localparam logic [1:0] MODE_TWOPASS = 2'b01;
  localparam logic [1:0] MODE_DOUBLE  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/adder_tree_sequencer_if.sv
// Job config, operand-beat, adder-tree return and result handshake bundle.
interface adder_tree_sequencer_if #(
  parameter int ACC_W = 66,
  parameter int LEN_W = 8
);
  logic             start;
  logic [1:0]       cfg_mode;
  logic [LEN_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] tree_sum;
  logic             tree_sign;
  logic [ACC_W-1:0] acc_in;
  logic [1:0]       mode;
  logic             clk_cntr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sign;
  logic             busy;

  modport master (
    output start, cfg_mode, cfg_len, in_valid, tree_sum, tree_sign, out_ready,
    input  in_ready, acc_in, mode, clk_cntr, out_valid, out_sum, out_sign, busy
  );

  modport slave (
    input  start, cfg_mode, cfg_len, in_valid, tree_sum, tree_sign, out_ready,
    output in_ready, acc_in, mode, clk_cntr, out_valid, out_sum, out_sign, busy
  );
endinterface

// File: rtl/acc_reg.sv
// Accumulator plus sign register: clear has priority over load; full-width load, no saturation.
module acc_reg #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_sign_d,
  output logic [W-1:0] o_q,
  output logic         o_sign
);
  logic [W-1:0] r_q;
  logic         r_sign;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_sign <= 1'b0;
    end else if (i_clr) begin
      r_q    <= '0;
      r_sign <= 1'b0;
    end else if (i_load) begin
      r_q    <= i_d;
      r_sign <= i_sign_d;
    end
  end

  assign o_q    = r_q;
  assign o_sign = r_sign;
endmodule

// File: rtl/adder_tree_sequencer.sv
// Sequences operand beats through an external adder tree, one or two passes per beat.
// Result held in DONE until out_ready; in_valid low stalls without any state change.
module adder_tree_sequencer #(
  parameter int ACC_W = adder_tree_pkg::ACC_W,
  parameter int LEN_W = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  adder_tree_sequencer_if.slave bus
);
  import adder_tree_pkg::*;

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_mode;
  logic [LEN_W:0]   r_cnt;
  logic             w_in_ready;
  logic             w_clk_cntr;
  logic             w_out_valid;
  logic             w_load;
  logic             w_dec;
  logic             w_accept;
  logic             w_twopass;
  logic             w_last;
  logic [ACC_W-1:0] w_acc;
  logic             w_sign;

  assign w_twopass = (r_mode == MODE_TWOPASS);
  assign w_last    = (r_cnt == CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_HALF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= bus.cfg_mode;
        // a zero length loads 2^LEN_W through the extra counter bit
        r_cnt  <= {(bus.cfg_len == '0), bus.cfg_len};
      end else if (w_dec) begin
        r_cnt  <= r_cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_clk_cntr  = 1'b0;
    w_out_valid = 1'b0;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = ST_PASS0;
        end
      end
      ST_PASS0: begin
        if (w_twopass) begin
          // first pass of a held beat: accumulate but do not acknowledge it yet
          if (bus.in_valid) begin
            w_load = 1'b1;
            w_next = ST_PASS1;
          end
        end else begin
          w_in_ready = 1'b1;
          if (bus.in_valid) begin
            w_load = 1'b1;
            w_dec  = 1'b1;
            if (w_last) w_next = ST_DONE;
          end
        end
      end
      ST_PASS1: begin
        w_clk_cntr = 1'b1;
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load = 1'b1;
          w_dec  = 1'b1;
          w_next = w_last ? ST_DONE : ST_PASS0;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  acc_reg #(.W(ACC_W)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_accept),
    .i_load   (w_load),
    .i_d      (bus.tree_sum),
    .i_sign_d (bus.tree_sign),
    .o_q      (w_acc),
    .o_sign   (w_sign)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.clk_cntr  = w_clk_cntr;
  assign bus.out_valid = w_out_valid;
  assign bus.acc_in    = w_acc;
  assign bus.out_sum   = w_acc;
  assign bus.out_sign  = w_sign;
  assign bus.mode      = r_mode;
  assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_adder_tree_sequencer.sv
// Randomised bench: tree model sum = acc_in + payload; expected result is the plain sum of consumed payloads.
module tb_adder_tree_sequencer;
  localparam int ACC_W = 66;
  localparam int LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic [ACC_W-1:0] r_pay;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adder_tree_sequencer_if #(.ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  assign bus.tree_sum  = bus.acc_in + r_pay;
  assign bus.tree_sign = bus.tree_sum[ACC_W-1];

  adder_tree_sequencer #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] rnd_pay();
    return ACC_W'({$urandom, $urandom, $urandom});
  endfunction

  // One cycle of the beat phase, checked at the negedge before the consuming edge.
  task automatic chk_beat_cycle(input logic exp_rdy, input logic exp_cc,
                                input logic [ACC_W-1:0] run, input logic [1:0] m);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("clk_cntr", bus.clk_cntr, exp_cc);
    chk("acc_in", bus.acc_in, run);
    chk("busy_job", bus.busy, 1'b1);
    chk("out_valid_job", bus.out_valid, 1'b0);
    chk("mode", bus.mode, m);
  endtask

  // gap_fixed >= 0 inserts that many idle cycles before every beat but the first.
  task automatic run_job(input logic [1:0] m, input int len, input int gap_max, input int gap_fixed,
                         input int hold, input logic fixed, input logic [ACC_W-1:0] pv);
    logic [ACC_W-1:0] run;
    logic [ACC_W-1:0] pay;
    int passes;
    int g;
    passes = (m == 2'b01) ? 2 : 1;
    run = '0;
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_in_ready", bus.in_ready, 1'b0);
    bus.start    = 1'b1;
    bus.cfg_mode = m;
    bus.cfg_len  = LEN_W'(len);
    @(negedge clk);
    bus.start = 1'b0;
    for (int b = 0; b < len; b++) begin
      pay = fixed ? pv : rnd_pay();
      g = (gap_fixed >= 0) ? ((b > 0) ? gap_fixed : 0) : int'($urandom_range(0, gap_max));
      for (int k = 0; k < g; k++) begin
        bus.in_valid = 1'b0;
        r_pay        = rnd_pay();
        bus.cfg_mode = 2'($urandom_range(0, 3));
        bus.cfg_len  = LEN_W'($urandom_range(0, 255));
        bus.start    = 1'($urandom_range(0, 1));
        chk_beat_cycle(passes == 1, 1'b0, run, m);
        @(negedge clk);
      end
      bus.start = 1'b0;
      for (int p = 0; p < passes; p++) begin
        bus.in_valid = 1'b1;
        r_pay        = pay;
        chk_beat_cycle((passes == 1) || (p == 1), p == 1, run, m);
        @(negedge clk);
        run = run + pay;
      end
      bus.in_valid = 1'b0;
    end
    chk("done_out_valid", bus.out_valid, 1'b1);
    chk("done_out_sum", bus.out_sum, run);
    chk("done_out_sign", bus.out_sign, run[ACC_W-1]);
    chk("done_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      bus.start    = 1'b1;
      bus.cfg_mode = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1'b1);
      chk("hold_out_sum", bus.out_sum, run);
      chk("hold_out_sign", bus.out_sign, run[ACC_W-1]);
      chk("hold_busy", bus.busy, 1'b1);
      chk("hold_mode", bus.mode, m);
    end
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    chk("ret_busy", bus.busy, 1'b0);
    chk("ret_out_valid", bus.out_valid, 1'b0);
    chk("ret_in_ready", bus.in_ready, 1'b0);
  endtask

  task automatic reset_mid_job();
    bus.start    = 1'b1;
    bus.cfg_mode = 2'b01;
    bus.cfg_len  = LEN_W'(2);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    r_pay        = ACC_W'(7);
    @(negedge clk);
    chk("rst_pre_clk_cntr", bus.clk_cntr, 1'b1);
    chk("rst_pre_acc", bus.acc_in, ACC_W'(7));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_acc_in", bus.acc_in, '0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_clk_cntr", bus.clk_cntr, 1'b0);
    chk("rst_mode", bus.mode, 2'b00);
    chk("rst_out_sign", bus.out_sign, 1'b0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_after_busy", bus.busy, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_mode  = 2'b00;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    r_pay         = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1'b0);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_clk_cntr", bus.clk_cntr, 1'b0);
    chk("reset_acc_in", bus.acc_in, '0);
    chk("reset_out_sum", bus.out_sum, '0);
    chk("reset_out_sign", bus.out_sign, 1'b0);
    chk("reset_mode", bus.mode, 2'b00);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(2'b00, 3, 0, 0, 0, 1'b1, ACC_W'(5));
    run_job(2'b01, 2, 0, 0, 0, 1'b1, ACC_W'(3));
    run_job(2'b00, 2, 0, 3, 0, 1'b1, ACC_W'(9));
    run_job(2'b10, 2, 0, 0, 4, 1'b0, '0);
    reset_mid_job();
    run_job(2'b10, 256, 0, 0, 1, 1'b1, ACC_W'(1));

    for (int j = 0; j < 30; j++) begin
      run_job(2'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 2, -1,
              int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_tree_sequencer.md
ADDER_TREE_SEQUENCER -- requirements
Module: adder_tree_sequencer

Interface
REQ-001 SHALL have parameter ACC_W, default 66, accumulator/adder-tree sum width.
REQ-002 SHALL have parameter LEN_W, default 8, beat-count width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  job request; honoured only in IDLE.
REQ-006 cfg_mode  input  2  job precision mode, latched on accepted start.
REQ-007 cfg_len  input  LEN_W  beats per job, latched on start; 0 means 2^LEN_W.
REQ-008 in_valid / in_ready  input / output  1 / 1  operand-beat handshake; beat consumed when both high.
REQ-009 tree_sum  input  ACC_W  combinational sum returned by the adder tree.
REQ-010 tree_sign  input  1  sign returned by the adder tree.
REQ-011 acc_in  output  ACC_W  accumulator value fed to the tree.
REQ-012 mode  output  2  latched mode driven to the tree.
REQ-013 clk_cntr  output  1  pass index for mode 2'b01.
REQ-014 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-015 out_sum  output  ACC_W  final accumulator; out_sign  output  1  final sign.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, PASS0, PASS1, DONE.
REQ-018 IDLE: start=1 SHALL latch cfg_mode/cfg_len, clear accumulator to 0, load beat counter, go to PASS0 next cycle.
REQ-019 acc_in SHALL equal the accumulator register at all times; mode SHALL equal the latched mode.
REQ-020 Modes 2'b00 and 2'b10: in_ready=1 in PASS0; each consumed beat SHALL load accumulator<=tree_sum, sign register<=tree_sign, decrement counter; clk_cntr=0.
REQ-021 Mode 2'b11 SHALL be handled identically to 2'b10.
REQ-022 Mode 2'b01: PASS0 SHALL drive clk_cntr=0, in_ready=0, and on in_valid=1 update accumulator/sign and go to PASS1; PASS1 SHALL drive clk_cntr=1, in_ready=1 and on in_valid=1 update accumulator/sign, decrement counter, return to PASS0 (upstream holds each beat two cycles).
REQ-023 in_valid=0 SHALL stall: no accumulator, sign, counter or state change.
REQ-024 When the final beat is consumed the FSM SHALL go to DONE next cycle; out_valid=1 only in DONE.
REQ-025 out_sum/out_sign SHALL equal accumulator/sign register, held stable while out_valid=1 and out_ready=0.
REQ-026 DONE with out_ready=1 SHALL return to IDLE next cycle; start in that same cycle is ignored.
REQ-027 start outside IDLE SHALL be ignored; cfg_* changes outside IDLE SHALL have no effect.
REQ-028 Latency: modes 00/10, N beats back-to-back -> out_valid N+1 cycles after start; mode 01 -> 2N+1 cycles.
REQ-029 in_ready SHALL be 0 in IDLE and DONE.
REQ-030 Accumulator update SHALL be a full-width ACC_W load of tree_sum; no saturation, wrap inherited from tree.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, accumulator=0, sign=0, counter=0, latched mode=2'b00, from any state including mid-job.
REQ-032 Reset values: in_ready=0, out_valid=0, busy=0, clk_cntr=0, acc_in=0, out_sum=0, out_sign=0, mode=2'b00.

Structure
REQ-033 Shared package adder_tree_pkg SHALL hold ACC_W, mode constants (MODE_HALF=2'b00, MODE_TWOPASS=2'b01, MODE_DOUBLE=2'b10) and the FSM state type.
REQ-034 The accumulator with clear/load enable SHALL be one sub-module, acc_reg.

Verification (bench tree model: tree_sum = acc_in + beat payload)
REQ-035 Mode 00, len=3, payloads 5,5,5 back-to-back -> out_valid at cycle 4 after start, out_sum=15.
REQ-036 Mode 01, len=2, payload 3 each pass -> clk_cntr 0,1,0,1; in_ready only on clk_cntr=1; out_sum=12 at cycle 5.
REQ-037 Mode 00, len=2, in_valid gap of 3 cycles between beats -> out_sum unchanged by gap, out_valid at cycle 6.
REQ-038 DONE with out_ready=0 for 4 cycles -> out_sum/out_sign stable, start pulse ignored, busy=1.
REQ-039 rst_n=0 during PASS1 of a mode 01 job -> next cycle IDLE, acc_in=0, in_ready=0, out_valid=0.
REQ-040 cfg_len=0, mode 10, payload 1 -> out_sum=256 after 256 beats.
